// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer feeding the dds configuration inputs.
// Steps f_word from f_start to f_stop with a programmable dwell per step.
module dds_sweep_ctrl #(
  parameter int FW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          abort,
  input  logic [1:0]    mode,
  input  logic [FW-1:0] f_start,
  input  logic [FW-1:0] f_stop,
  input  logic [FW-1:0] f_step,
  input  logic [DW-1:0] dwell,
  input  logic [1:0]    sel_in,
  input  logic [1:0]    amp_in,
  input  logic [FW-1:0] p_in,
  output logic          wave_ena,
  output logic [1:0]    wave_sel,
  output logic [1:0]    wave_amp,
  output logic [FW-1:0] f_word,
  output logic [FW-1:0] p_word,
  output logic          busy,
  output logic          done,
  output logic          step_tick,
  output logic          cfg_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, UP = 2'd1, DOWN = 2'd2} state_t;

  state_t        state, state_nxt;
  logic [FW-1:0] f_word_nxt;
  logic [DW-1:0] cnt, cnt_nxt, dwell_m1, dwell_m1_in;
  logic [1:0]    mode_q, mode_in;
  logic [FW-1:0] start_q, stop_q, step_q;
  logic          done_nxt, tick_nxt, err_nxt, latch;
  logic [FW:0]   up_sum, dn_dif;
  logic [FW-1:0] up_val, dn_val;

  assign dwell_m1_in = (dwell == '0) ? '0 : dwell - DW'(1);
  assign mode_in     = (mode == 2'b11) ? 2'b00 : mode;

  // Saturating step arithmetic in FW+1 bits so neither direction wraps.
  assign up_sum = {1'b0, f_word} + {1'b0, step_q};
  assign dn_dif = {1'b0, f_word} - {1'b0, step_q};
  assign up_val = (up_sum > {1'b0, stop_q}) ? stop_q : up_sum[FW-1:0];
  assign dn_val = (dn_dif[FW] || (dn_dif[FW-1:0] < start_q)) ? start_q : dn_dif[FW-1:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      f_word    <= '0;
      cnt       <= '0;
      done      <= 1'b0;
      step_tick <= 1'b0;
      cfg_err   <= 1'b0;
      mode_q    <= '0;
      start_q   <= '0;
      stop_q    <= '0;
      step_q    <= '0;
      dwell_m1  <= '0;
      wave_sel  <= '0;
      wave_amp  <= '0;
      p_word    <= '0;
    end else begin
      state     <= state_nxt;
      f_word    <= f_word_nxt;
      cnt       <= cnt_nxt;
      done      <= done_nxt;
      step_tick <= tick_nxt;
      cfg_err   <= err_nxt;
      if (latch) begin
        mode_q   <= mode_in;
        start_q  <= f_start;
        stop_q   <= f_stop;
        step_q   <= f_step;
        dwell_m1 <= dwell_m1_in;
        wave_sel <= sel_in;
        wave_amp <= amp_in;
        p_word   <= p_in;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    f_word_nxt = f_word;
    cnt_nxt    = cnt;
    done_nxt   = 1'b0;
    tick_nxt   = 1'b0;
    err_nxt    = 1'b0;
    latch      = 1'b0;
    if (abort) begin
      state_nxt  = IDLE;
      f_word_nxt = '0;
      cnt_nxt    = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (f_step == '0 || f_start > f_stop) begin
              err_nxt = 1'b1;
            end else begin
              latch      = 1'b1;
              state_nxt  = UP;
              f_word_nxt = f_start;
              cnt_nxt    = dwell_m1_in;
              tick_nxt   = 1'b1;
            end
          end
        end
        UP: begin
          if (cnt == '0) begin
            cnt_nxt  = dwell_m1;
            tick_nxt = 1'b1;
            if (f_word != stop_q) begin
              f_word_nxt = up_val;
            end else begin
              case (mode_q)
                2'b01: f_word_nxt = start_q;
                2'b10: begin
                  state_nxt  = DOWN;
                  f_word_nxt = dn_val;
                end
                default: begin
                  state_nxt  = IDLE;
                  f_word_nxt = '0;
                  cnt_nxt    = '0;
                  tick_nxt   = 1'b0;
                  done_nxt   = 1'b1;
                end
              endcase
            end
          end else begin
            cnt_nxt = cnt - DW'(1);
          end
        end
        DOWN: begin
          if (cnt == '0) begin
            cnt_nxt  = dwell_m1;
            tick_nxt = 1'b1;
            if (f_word != start_q) begin
              f_word_nxt = dn_val;
            end else begin
              // Turnaround: f_word equals start_q here, so up_val is min(start+step, stop).
              state_nxt  = UP;
              f_word_nxt = up_val;
            end
          end else begin
            cnt_nxt = cnt - DW'(1);
          end
        end
        default: begin
          state_nxt  = IDLE;
          f_word_nxt = '0;
          cnt_nxt    = '0;
        end
      endcase
    end
  end

  always_comb begin
    busy     = (state != IDLE);
    wave_ena = busy;
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: hand-computed f_word/flag sequences per scenario.
module tb_dds_sweep_ctrl;
  localparam int FW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0, rstn = 1'b1, start = 1'b0, abort = 1'b0;
  logic [1:0]    mode = '0, sel_in = '0, amp_in = '0;
  logic [FW-1:0] f_start = '0, f_stop = '0, f_step = '0, p_in = '0;
  logic [DW-1:0] dwell = '0;
  logic          wave_ena, busy, done, step_tick, cfg_err;
  logic [1:0]    wave_sel, wave_amp;
  logic [FW-1:0] f_word, p_word;

  int nvec = 0;
  int nerr = 0;
  logic [FW+2:0] obs [0:63];  // {busy, done, step_tick, f_word}

  dds_sweep_ctrl #(.FW(FW), .DW(DW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .mode(mode),
    .f_start(f_start), .f_stop(f_stop), .f_step(f_step), .dwell(dwell),
    .sel_in(sel_in), .amp_in(amp_in), .p_in(p_in),
    .wave_ena(wave_ena), .wave_sel(wave_sel), .wave_amp(wave_amp),
    .f_word(f_word), .p_word(p_word), .busy(busy), .done(done),
    .step_tick(step_tick), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic cfg(input logic [1:0] m, input logic [FW-1:0] a, input logic [FW-1:0] b,
                     input logic [FW-1:0] s, input logic [DW-1:0] d);
    mode = m; f_start = a; f_stop = b; f_step = s; dwell = d;
  endtask

  task automatic kick;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic do_abort;
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      obs[i] = {busy, done, step_tick, f_word};
    end
  endtask

  task automatic test_reset;
    #1 rstn = 1'b0;
    #2;
    nvec++;
    if ({wave_ena, busy, done, step_tick, cfg_err, wave_sel, wave_amp, f_word, p_word} !== '0) begin
      nerr++;
      $display("FAIL reset_state: got ena=%b busy=%b done=%b tick=%b err=%b sel=%0d amp=%0d f=%0d p=%0d, want all 0",
               wave_ena, busy, done, step_tick, cfg_err, wave_sel, wave_amp, f_word, p_word);
    end
    @(negedge clk); rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single;
    logic [FW+2:0] exp;
    cfg(2'b00, 8'd10, 8'd40, 8'd10, 16'd4);
    sel_in = 2'd2; amp_in = 2'd3; p_in = 8'h5A;
    kick;
    capture(20);
    for (int i = 0; i < 20; i++) begin
      if (i < 16)       exp = {1'b1, 1'b0, (i % 4 == 0), FW'(10 + 10 * (i / 4))};
      else if (i == 16) exp = {1'b0, 1'b1, 1'b0, 8'd0};
      else              exp = '0;
      nvec++;
      if (obs[i] !== exp) begin
        nerr++;
        $display("FAIL single[%0d]: got busy/done/tick/f=%h, want %h", i, obs[i], exp);
      end
    end
    nvec++;
    if ({wave_ena, wave_sel, wave_amp, p_word} !== {1'b0, 2'd2, 2'd3, 8'h5A}) begin
      nerr++;
      $display("FAIL single_latch: got ena=%b sel=%0d amp=%0d p=%h, want 0 2 3 5a",
               wave_ena, wave_sel, wave_amp, p_word);
    end
  endtask

  task automatic test_nonmult;
    logic [FW+2:0] exp;
    int v1 [4] = '{10, 20, 30, 35};
    int v2 [3] = '{200, 240, 255};
    cfg(2'b00, 8'd10, 8'd35, 8'd10, 16'd0);
    kick;
    capture(6);
    for (int i = 0; i < 6; i++) begin
      exp = (i < 4) ? {1'b1, 1'b0, 1'b1, FW'(v1[i])} : (i == 4) ? {1'b0, 1'b1, 1'b0, 8'd0} : '0;
      nvec++;
      if (obs[i] !== exp) begin
        nerr++;
        $display("FAIL nonmult[%0d]: got %h, want %h", i, obs[i], exp);
      end
    end
    cfg(2'b00, 8'd200, 8'd255, 8'd40, 16'd1);
    kick;
    capture(5);
    for (int i = 0; i < 5; i++) begin
      exp = (i < 3) ? {1'b1, 1'b0, 1'b1, FW'(v2[i])} : (i == 3) ? {1'b0, 1'b1, 1'b0, 8'd0} : '0;
      nvec++;
      if (obs[i] !== exp) begin
        nerr++;
        $display("FAIL nowrap[%0d]: got %h, want %h", i, obs[i], exp);
      end
    end
    cfg(2'b11, 8'd10, 8'd20, 8'd10, 16'd1);
    kick;
    capture(4);
    for (int i = 0; i < 4; i++) begin
      exp = (i < 2) ? {1'b1, 1'b0, 1'b1, FW'(10 + 10 * i)} : (i == 2) ? {1'b0, 1'b1, 1'b0, 8'd0} : '0;
      nvec++;
      if (obs[i] !== exp) begin
        nerr++;
        $display("FAIL mode3[%0d]: got %h, want %h", i, obs[i], exp);
      end
    end
  endtask

  task automatic test_repeat;
    logic [FW+2:0] exp;
    int r [3] = '{10, 20, 30};
    cfg(2'b01, 8'd10, 8'd30, 8'd10, 16'd2);
    kick;
    capture(13);
    for (int i = 0; i < 13; i++) begin
      exp = {1'b1, 1'b0, (i % 2 == 0), FW'(r[(i / 2) % 3])};
      nvec++;
      if (obs[i] !== exp) begin
        nerr++;
        $display("FAIL repeat[%0d]: got %h, want %h", i, obs[i], exp);
      end
    end
    do_abort;
    capture(3);
    for (int i = 0; i < 3; i++) begin
      nvec++;
      if (obs[i] !== '0) begin
        nerr++;
        $display("FAIL repeat_abort[%0d]: got %h, want 0", i, obs[i]);
      end
    end
    nvec++;
    if (wave_ena !== 1'b0) begin
      nerr++;
      $display("FAIL abort_ena: got %b, want 0", wave_ena);
    end
  endtask

  task automatic test_triangle;
    logic [FW+2:0] exp;
    int t [4] = '{10, 20, 30, 20};
    cfg(2'b10, 8'd10, 8'd30, 8'd10, 16'd2);
    kick;
    capture(20);
    for (int i = 0; i < 20; i++) begin
      exp = {1'b1, 1'b0, (i % 2 == 0), FW'(t[(i / 2) % 4])};
      nvec++;
      if (obs[i] !== exp) begin
        nerr++;
        $display("FAIL triangle[%0d]: got %h, want %h", i, obs[i], exp);
      end
    end
    do_abort;
    cfg(2'b10, 8'd50, 8'd50, 8'd10, 16'd1);
    kick;
    capture(6);
    for (int i = 0; i < 6; i++) begin
      exp = {1'b1, 1'b0, 1'b1, 8'd50};
      nvec++;
      if (obs[i] !== exp) begin
        nerr++;
        $display("FAIL tri_flat[%0d]: got %h, want %h", i, obs[i], exp);
      end
    end
    do_abort;
    @(negedge clk);
    nvec++;
    if ({busy, f_word, done} !== '0) begin
      nerr++;
      $display("FAIL tri_abort: got busy=%b f=%0d done=%b, want 0 0 0", busy, f_word, done);
    end
  endtask

  task automatic test_reject;
    cfg(2'b00, 8'd10, 8'd40, 8'd0, 16'd1);
    kick;
    @(negedge clk);
    nvec++;
    if ({cfg_err, busy, f_word} !== {1'b1, 1'b0, 8'd0}) begin
      nerr++;
      $display("FAIL step0: got err=%b busy=%b f=%0d, want 1 0 0", cfg_err, busy, f_word);
    end
    @(negedge clk);
    nvec++;
    if ({cfg_err, busy} !== 2'b00) begin
      nerr++;
      $display("FAIL step0_pulse: got err=%b busy=%b, want 0 0", cfg_err, busy);
    end
    cfg(2'b00, 8'd40, 8'd10, 8'd10, 16'd1);
    kick;
    @(negedge clk);
    nvec++;
    if ({cfg_err, busy} !== 2'b10) begin
      nerr++;
      $display("FAIL inverted: got err=%b busy=%b, want 1 0", cfg_err, busy);
    end
    // start+abort together: valid config must not start, invalid must not flag
    cfg(2'b00, 8'd10, 8'd40, 8'd10, 16'd1);
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    @(negedge clk);
    nvec++;
    if ({cfg_err, busy, step_tick, f_word} !== '0) begin
      nerr++;
      $display("FAIL start_abort: got err=%b busy=%b tick=%b f=%0d, want all 0", cfg_err, busy, step_tick, f_word);
    end
    cfg(2'b00, 8'd10, 8'd40, 8'd0, 16'd1);
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    @(negedge clk);
    nvec++;
    if ({cfg_err, busy} !== 2'b00) begin
      nerr++;
      $display("FAIL start_abort_bad: got err=%b busy=%b, want 0 0", cfg_err, busy);
    end
  endtask

  task automatic test_back_to_back;
    logic [FW+2:0] exp;
    cfg(2'b00, 8'd10, 8'd40, 8'd10, 16'd4);
    sel_in = 2'd1; amp_in = 2'd1; p_in = 8'h33;
    kick;
    capture(3);
    for (int i = 0; i < 3; i++) begin
      exp = {1'b1, 1'b0, (i == 0), 8'd10};
      nvec++;
      if (obs[i] !== exp) begin
        nerr++;
        $display("FAIL b2b_pre[%0d]: got %h, want %h", i, obs[i], exp);
      end
    end
    cfg(2'b01, 8'd99, 8'd120, 8'd1, 16'd1);
    sel_in = 2'd3; amp_in = 2'd2; p_in = 8'hEE;
    kick;
    capture(14);
    for (int j = 0; j < 14; j++) begin
      int i;
      i = j + 3;
      exp = (i < 16) ? {1'b1, 1'b0, (i % 4 == 0), FW'(10 + 10 * (i / 4))} : {1'b0, 1'b1, 1'b0, 8'd0};
      nvec++;
      if (obs[j] !== exp) begin
        nerr++;
        $display("FAIL b2b[%0d]: got %h, want %h", i, obs[j], exp);
      end
    end
    nvec++;
    if ({wave_sel, wave_amp, p_word} !== {2'd1, 2'd1, 8'h33}) begin
      nerr++;
      $display("FAIL b2b_latch: got sel=%0d amp=%0d p=%h, want 1 1 33", wave_sel, wave_amp, p_word);
    end
  endtask

  task automatic test_async_reset;
    logic [FW+2:0] exp;
    cfg(2'b01, 8'd10, 8'd30, 8'd10, 16'd2);
    sel_in = 2'd1; amp_in = 2'd1; p_in = 8'h11;
    kick;
    repeat (3) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    nvec++;
    if ({wave_ena, busy, done, step_tick, cfg_err, wave_sel, wave_amp, f_word, p_word} !== '0) begin
      nerr++;
      $display("FAIL async_reset: got ena=%b busy=%b sel=%0d amp=%0d f=%0d p=%h, want all 0",
               wave_ena, busy, wave_sel, wave_amp, f_word, p_word);
    end
    @(negedge clk);
    rstn = 1'b1;
    cfg(2'b00, 8'd20, 8'd30, 8'd10, 16'd1);
    sel_in = 2'd2; amp_in = 2'd2; p_in = 8'h77;
    kick;
    capture(4);
    for (int i = 0; i < 4; i++) begin
      exp = (i < 2) ? {1'b1, 1'b0, 1'b1, FW'(20 + 10 * i)} : (i == 2) ? {1'b0, 1'b1, 1'b0, 8'd0} : '0;
      nvec++;
      if (obs[i] !== exp) begin
        nerr++;
        $display("FAIL post_reset[%0d]: got %h, want %h", i, obs[i], exp);
      end
    end
    nvec++;
    if ({wave_sel, wave_amp, p_word} !== {2'd2, 2'd2, 8'h77}) begin
      nerr++;
      $display("FAIL post_reset_latch: got sel=%0d amp=%0d p=%h, want 2 2 77", wave_sel, wave_amp, p_word);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_nonmult;
    test_repeat;
    test_triangle;
    test_reject;
    test_back_to_back;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
Frequency-sweep sequencer that drives the configuration inputs of the dds block: wave_ena, wave_sel, wave_amp, f_word and p_word. It steps f_word from a start word to a stop word in fixed increments, holding each frequency for a programmable dwell. Three sweep modes are supported: single, repeating sawtooth and triangle. It sits between the register/host logic and dds, and its outputs connect directly to the dds inputs of the same names.

Parameters:
FW, 8, frequency/phase word width (matches dds f_word/p_word)
DW, 16, dwell counter width

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous active-low reset
start  input  1  single-cycle request to begin a sweep; sampled only in IDLE
abort  input  1  stop the sweep immediately; honoured in any state
mode  input  2  00 single, 01 repeat (sawtooth), 10 triangle, 11 treated as 00
f_start  input  FW  first frequency word
f_stop  input  FW  last frequency word
f_step  input  FW  increment per step
dwell  input  DW  cycles per frequency; 0 treated as 1
sel_in  input  2  waveform select, latched at start
amp_in  input  2  amplitude code, latched at start
p_in  input  FW  phase word, latched at start
wave_ena  output  1  dds enable; 1 while busy
wave_sel  output  2  latched sel_in
wave_amp  output  2  latched amp_in
f_word  output  FW  current frequency word; 0 when idle
p_word  output  FW  latched p_in
busy  output  1  sweep active
done  output  1  one-cycle pulse when a single-mode sweep completes
step_tick  output  1  one-cycle pulse in the cycle after f_word is loaded with a new value
cfg_err  output  1  one-cycle pulse when start is rejected

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rstn). All state is registered on the rising edge of clk.
- Reset values: all outputs are 0; state is IDLE; the dwell counter is 0. Reset asserted mid-sweep returns the block to IDLE immediately, and no done pulse is issued.
- States: IDLE, UP, DOWN.
- IDLE: wave_ena=0, busy=0, f_word=0. wave_sel, wave_amp and p_word keep their last latched values.
- Start in IDLE with f_step==0 or f_start>f_stop: start is ignored, cfg_err=1 for 1 cycle, and the block stays in IDLE.
- Valid start in IDLE, sampled at edge k. At edge k the block:
  - latches mode, f_start, f_stop, f_step, dwell_eff and sel/amp/p;
  - sets f_word=f_start, busy=1, wave_ena=1;
  - loads the dwell counter with dwell_eff-1;
  - moves to state UP.
  step_tick=1 in the cycle after edge k.
- Dwell: the counter decrements each cycle. When the counter is 0 at a clock edge, that edge is a step boundary and the counter reloads to dwell_eff-1. Each f_word value is therefore held exactly dwell_eff cycles.
- UP at a boundary:
  - If f_word!=f_stop: f_word = min(f_word+f_step, f_stop). The sum is computed in FW+1 bits, so it never wraps.
  - If f_word==f_stop and mode is single: go to IDLE, done=1 for 1 cycle, busy=0 and wave_ena=0 in that same cycle, f_word=0.
  - If f_word==f_stop and mode is repeat: f_word=f_start, stay in UP.
  - If f_word==f_stop and mode is triangle: go to DOWN, f_word = max(f_word-f_step, f_start), computed without underflow.
- DOWN at a boundary:
  - If f_word!=f_start: f_word = max(f_word-f_step, f_start).
  - If f_word==f_start: go to UP, f_word = min(f_start+f_step, f_stop).
- Triangle endpoints are held for one dwell only. When f_start==f_stop the word stays constant and the state alternates. Triangle mode ends only on abort.
- step_tick pulses on every boundary that loads f_word, including the repeat wrap and the triangle turnarounds. It does not pulse on the transition to IDLE.
- abort: at the next edge from any state, go to IDLE with f_word=0, busy=0 and wave_ena=0. done and step_tick are not pulsed.
- abort and start asserted in the same cycle while in IDLE: abort wins and start is dropped (no cfg_err).
- start while busy: ignored. Input configuration changes while busy have no effect until the next start.
- done and cfg_err never assert in the same cycle.

Test Plan:
- Single sweep, f_start=10, f_stop=40, f_step=10, dwell=4 -> f_word runs 10,20,30,40 with each value held 4 cycles; step_tick pulses 4 times; done pulses exactly 16 cycles after the start edge; busy and wave_ena then fall and f_word becomes 0.
- Non-multiple and no-wrap cases: stop=35 gives 10,20,30,35 then done; f_start=200, f_stop=255, f_step=40 gives 200,240,255 (no wrap to 24); dwell=0 holds each value 1 cycle.
- Repeat mode, 10..30, step 10, dwell 2 -> 10,20,30,10,20,30... continues until abort; abort mid-dwell drives f_word=0 and busy=0 on the next edge, with no done pulse.
- Triangle mode, 10..30, step 10, dwell 2 -> 10,20,30,20,10,20,30,20... with each endpoint held 2 cycles; f_start=f_stop=50 holds f_word=50 constant.
- Rejection and contention: f_step=0 -> cfg_err pulse and busy stays 0; f_start=40 with f_stop=10 -> cfg_err; start during a sweep is ignored; start and abort in the same cycle in IDLE -> nothing happens.
- Reset mid-sweep with rstn low, asynchronous to clk -> all outputs 0 immediately; after release a fresh start runs normally with the new sel/amp/p latched.
